// File: rtl/serial_byte_comparator.sv
// serial_byte_comparator
//   Multi-byte magnitude comparator. Operand pairs stream in one byte per beat,
//   most significant byte first, on a valid/ready input. The first unequal byte
//   decides the verdict. If every byte is equal, the cascade seed captured with
//   the first beat is returned verbatim. The result is held on a valid/ready
//   output until it is consumed.
//
//   Optional feature macro: SERIAL_CMP_SIGNED_EN
//     defined   : the in_first byte is compared as two's complement, so the whole
//                 operand compare is signed. Later bytes stay unsigned.
//     undefined : every byte is compared unsigned.
//
// Parameters
//   WIDTH  bits per beat (a_byte / b_byte)
//   CNT_W  width of byte_count; the count saturates at 2**CNT_W-1
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_first/in_last    beat framing (MSB beat / LSB beat)
//   a_byte, b_byte      operand slices
//   lin, ein, gin       cascade seed, sampled with the in_first beat
//   out_valid/out_ready result handshake
//   less/equal/greater  registered result
//   byte_count          beats accepted in the current/last compare
//   proto_err           one-cycle pulse on a framing violation

// Per-beat slice comparator. When sgn is set the slice is treated as two's
// complement by sign-extending one bit; otherwise it is zero-extended.
module serial_byte_comparator_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             lt,
  output logic             gt
);
  logic signed [WIDTH:0] ax, bx;

  always_comb begin
    ax = $signed({sgn & a[WIDTH-1], a});
    bx = $signed({sgn & b[WIDTH-1], b});
    lt = (ax < bx);
    gt = (ax > bx);
  end
endmodule

module serial_byte_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a_byte,
  input  logic [WIDTH-1:0] b_byte,
  input  logic             lin,
  input  logic             ein,
  input  logic             gin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic [CNT_W-1:0] byte_count,
  output logic             proto_err
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   decided;     // an unequal byte has been seen in this compare
  logic   verdict_gt;  // valid when decided: 1 = A>B, 0 = A<B
  res_t   seed_q;
  res_t   pend_res;    // result staged for the output register stage
  logic   res_pend;    // HOLD entered, result lands on out_* next cycle

  logic             acc, start, sgn;
  logic             beat_lt, beat_gt;
  logic             dec_base, ver_base, nxt_decided, nxt_gt;
  res_t             seed_base, nxt_res;
  logic [CNT_W-1:0] cnt_base, nxt_cnt;

  assign acc = in_valid & in_ready;
  // A first beat (from IDLE or as a restart from ACC) discards prior context.
  assign start = in_first;

`ifdef SERIAL_CMP_SIGNED_EN
  assign sgn = in_first;
`else
  assign sgn = 1'b0;
`endif

  serial_byte_comparator_lane #(.WIDTH(WIDTH)) u_lane (
    .a   (a_byte),
    .b   (b_byte),
    .sgn (sgn),
    .lt  (beat_lt),
    .gt  (beat_gt)
  );

  // Fold the current beat into the running compare state. The current beat
  // participates in the verdict, so a single first+last beat is complete.
  always_comb begin
    dec_base    = start ? 1'b0 : decided;
    ver_base    = start ? 1'b0 : verdict_gt;
    seed_base   = start ? res_t'{lt: lin, eq: ein, gt: gin} : seed_q;
    nxt_decided = dec_base | beat_lt | beat_gt;
    nxt_gt      = dec_base ? ver_base : beat_gt;
    if (nxt_decided)
      nxt_res = nxt_gt ? res_t'{lt: 1'b0, eq: 1'b0, gt: 1'b1}
                       : res_t'{lt: 1'b1, eq: 1'b0, gt: 1'b0};
    else
      nxt_res = seed_base;
    cnt_base = start ? '0 : byte_count;
    nxt_cnt  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      less       <= 1'b0;
      equal      <= 1'b0;
      greater    <= 1'b0;
      byte_count <= '0;
      proto_err  <= 1'b0;
      decided    <= 1'b0;
      verdict_gt <= 1'b0;
      seed_q     <= '0;
      pend_res   <= '0;
      res_pend   <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        IDLE, ACC: begin
          if (acc) begin
            if (state == IDLE && !in_first) begin
              // Orphan beat: dropped without touching compare state.
              proto_err <= 1'b1;
            end else begin
              if (state == ACC && in_first)
                proto_err <= 1'b1;
              decided    <= nxt_decided;
              verdict_gt <= nxt_gt;
              seed_q     <= seed_base;
              byte_count <= nxt_cnt;
              if (in_last) begin
                state    <= HOLD;
                in_ready <= 1'b0;
                res_pend <= 1'b1;
                pend_res <= nxt_res;
              end else begin
                state <= ACC;
              end
            end
          end
        end
        HOLD: begin
          if (res_pend) begin
            // Results appear one cycle after the last beat is accepted.
            less      <= pend_res.lt;
            equal     <= pend_res.eq;
            greater   <= pend_res.gt;
            out_valid <= 1'b1;
            res_pend  <= 1'b0;
          end else if (out_ready) begin
            // Results stay put; in_ready reopens from the next cycle.
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          res_pend  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_byte_comparator.sv
// Self-checking bench for serial_byte_comparator: table-driven compares with a
// result scoreboard, plus hand-written latency, framing, backpressure,
// reset and saturation sequences.
module tb_serial_byte_comparator;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_first, in_last;
  logic [7:0] a_byte, b_byte;
  logic       lin, ein, gin;
  logic       out_valid, out_ready;
  logic       less, equal, greater;
  logic [4:0] byte_count;
  logic       proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_byte_comparator #(.WIDTH(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .a_byte(a_byte), .b_byte(b_byte),
    .lin(lin), .ein(ein), .gin(gin),
    .out_valid(out_valid), .out_ready(out_ready),
    .less(less), .equal(equal), .greater(greater),
    .byte_count(byte_count), .proto_err(proto_err)
  );

  typedef struct {
    int          n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  seed;  // {lin,ein,gin}
    logic [2:0]  res;   // {less,equal,greater}
    int          cnt;
  } vec_t;

  typedef struct {
    logic [2:0] res;
    logic [4:0] cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: a result is consumed at the edge following a negedge that
  // sees out_valid & out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got lge=%b cnt=%0d with empty scoreboard",
                 {less, equal, greater}, byte_count);
      end else begin
        mon_e = sbq.pop_front();
        if ({less, equal, greater} !== mon_e.res || byte_count !== mon_e.cnt) begin
          failures++;
          $display("FAIL result: got lge=%b cnt=%0d expected lge=%b cnt=%0d",
                   {less, equal, greater}, byte_count, mon_e.res, mon_e.cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
  endtask

  // Present one beat and hold it until accepted.
  task automatic beat(input logic f, input logic l, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] seed);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    a_byte   = a;
    b_byte   = b;
    {lin, ein, gin} = seed;
    wait_ready();
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send an n-byte compare, MSB first; bytes above bit 31 are zero.
  task automatic send(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] seed, input logic [2:0] res, input int cnt);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int k = n - 1 - i;
      if (i == n - 1) begin
        e.res = res;
        e.cnt = 5'(cnt);
        sbq.push_back(e);
      end
      beat(i == 0, i == n - 1,
           (k < 4) ? 8'(a >> (8 * k)) : 8'h00,
           (k < 4) ? 8'(b >> (8 * k)) : 8'h00,
           seed);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1, 32'h0B,       32'h07,       3'b010, 3'b001, 1};
    vecs[1] = '{3, 32'h100000,   32'h0FFFFF,   3'b000, 3'b001, 3};
    vecs[2] = '{2, 32'h8B8B,     32'h8B8B,     3'b100, 3'b100, 2};
    vecs[3] = '{2, 32'h8B8B,     32'h8B8B,     3'b010, 3'b010, 2};
    vecs[4] = '{2, 32'h1234,     32'h1235,     3'b001, 3'b100, 2};
    vecs[5] = '{4, 32'h01020304, 32'h01020304, 3'b111, 3'b111, 4};
    vecs[6] = '{2, 32'h0580,     32'h057F,     3'b000, 3'b001, 2};
    vecs[7] = '{3, 32'h00FF00,   32'h0001FF,   3'b000, 3'b001, 3};
    vecs[8] = '{1, 32'h00,       32'h00,       3'b000, 3'b000, 1};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a_byte = '0; b_byte = '0; {lin, ein, gin} = 3'b000; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready",  32'(in_ready), 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_lge",       32'({less, equal, greater}), 0);
    chk("reset_count",     32'(byte_count), 0);
    chk("reset_proto_err", 32'(proto_err), 0);

    // Latency: result lands one cycle after the last beat's accepting edge.
    send(1, 32'h0B, 32'h07, 3'b010, 3'b001, 1);
    chk("lat_t0_out_valid", 32'(out_valid), 0);
    tick();
    chk("lat_t1_out_valid", 32'(out_valid), 1);
    chk("lat_t1_greater",   32'(greater), 1);
    chk("lat_t1_count",     32'(byte_count), 1);
    drain();

    for (int i = 0; i < 9; i++)
      send(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].seed, vecs[i].res, vecs[i].cnt);
    drain();

    // Orphan beat in IDLE is dropped and flagged for one cycle.
    beat(1'b0, 1'b1, 8'h01, 8'h02, 3'b000);
    chk("orphan_proto_err", 32'(proto_err), 1);
    chk("orphan_no_result", 32'(out_valid), 0);
    tick();
    chk("orphan_pulse_end", 32'(proto_err), 0);

    // Restart mid-compare with a new seed; the old decided byte is discarded.
    beat(1'b1, 1'b0, 8'h10, 8'h01, 3'b100);
    chk("acc_no_err",   32'(proto_err), 0);
    beat(1'b1, 1'b0, 8'h22, 8'h22, 3'b001);
    chk("restart_proto_err", 32'(proto_err), 1);
    chk("restart_count",     32'(byte_count), 1);
    sbq.push_back('{3'b001, 5'd2});
    beat(1'b0, 1'b1, 8'h33, 8'h33, 3'b000);
    drain();

    // Backpressure in HOLD.
    out_ready = 1'b0;
    send(2, 32'h1234, 32'h1235, 3'b000, 3'b100, 2);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready",  32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_lge",       32'({less, equal, greater}), 32'b100);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_ready_seen_in_ready", 32'(in_ready), 0);
    tick();
    chk("bp_exit_out_valid", 32'(out_valid), 0);
    chk("bp_exit_in_ready",  32'(in_ready), 1);
    chk("bp_results_kept",   32'({less, equal, greater}), 32'b100);
    drain();

    // Reset during beat 2 of 3.
    beat(1'b1, 1'b0, 8'h01, 8'h02, 3'b000);
    in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0;
    a_byte = 8'h05; b_byte = 8'h05;
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 0);
    chk("rst_mid_in_ready",  32'(in_ready), 1);
    chk("rst_mid_lge",       32'({less, equal, greater}), 0);
    chk("rst_mid_count",     32'(byte_count), 0);
    chk("rst_mid_proto_err", 32'(proto_err), 0);
`ifdef SERIAL_CMP_SIGNED_EN
    send(1, 32'h00, 32'hFF, 3'b000, 3'b001, 1);
`else
    send(1, 32'h00, 32'hFF, 3'b000, 3'b100, 1);
`endif
    drain();

    // byte_count saturation: 33 equal beats.
    send(33, 32'h0, 32'h0, 3'b010, 3'b010, 31);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
